tcore_mem_arbiter: RTL and testbench
====================================

Name: tcore_mem_arbiter

Overview:
- Shares the single external memory port (mem_req_t) between the instruction-side lowX path (ilowX_req_t/ilowX_res_t) and the data-side lowX path (dlowX_req_t/dlowX_res_t).
- Round-robin arbitration with one outstanding transaction.
- Forms the 16-bit byte-write mask and returns the 128-bit block to the granted requester.
- Bounded response timeout with an error pulse.

Parameters:
- TIMEOUT_CYC, 1024, cycles waited in WAIT for mem_res_i.valid before forcing an error response; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYC+1), timeout counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- iX_req_i  in  ilowX_req_t(35)  fetch request; ready = requester accepts response.
- iX_res_o  out  ilowX_res_t(130)  ready = request accepted (1-cycle pulse); valid+blk = response.
- dX_req_i  in  dlowX_req_t(166)  data request; ready = requester accepts response.
- dX_res_o  out  dlowX_res_t(130)  same semantics as iX_res_o.
- mem_req_o  out  mem_req_t(177)  valid, addr, data, rw byte mask.
- mem_ready_i  in  1  memory accepts mem_req_o this cycle.
- mem_res_i  in  mem_res_t(129)  valid + 128-bit data (read data or write ack).
- err_o  out  1  1-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_last=DATA (instruction wins the first tie), counter 0. Takes effect immediately, including mid-transaction. A late mem_res_i after reset is ignored.
- Requester rule: req.valid stays high with stable fields until its res.valid && req.ready handshake.
- FSM IDLE:
  - No valid: stay.
  - One valid: grant it.
  - Both valid: grant the one not equal to rr_last.
  - On grant: pulse granted res.ready, latch request into mem_req register, record gnt, go REQ.
- FSM REQ:
  - mem_req_o.valid=1, fields stable.
  - On mem_ready_i: go WAIT, clear counter.
- FSM WAIT:
  - mem_req_o.valid=0; counter increments each cycle.
  - On mem_res_i.valid: latch data, go RESP.
  - If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 without valid: latch data=0, pulse err_o, go RESP.
  - If mem_res_i.valid arrives in the timeout cycle, valid wins and err_o stays 0.
- FSM RESP:
  - Granted res.valid=1 with blk/data; the other side's res.valid=0.
  - On granted req.ready: go IDLE, rr_last=gnt.
  - New grant earliest next cycle (no IDLE bypass).
- mem_res_i.valid in IDLE/REQ/RESP: ignored.
- Address: cached → {addr[31:4],4'b0}; uncached → addr unchanged. Instruction side is always read.
- Mask (data side):
  - rw=0 → 16'h0000.
  - rw=1 && !uncached → 16'hFFFF.
  - rw=1 && uncached, a=addr[3:0]:
    - BYTE: 16'h1<<a.
    - HALF_WORD: 16'h3<<{a[3:1],1'b0}.
    - WORD: 16'hF<<{a[3:2],2'b00}.
    - NO_SIZE: 16'h0000.
- Data: passed unchanged; the requester supplies lane-aligned data. Instruction-side data=0.
- Minimum latency: grant cycle, REQ, WAIT (response same cycle), RESP → res.valid 3 cycles after req.valid when memory is always ready.
- Only one transaction is outstanding; the non-granted requester waits and is granted next by round-robin.

Decomposition:
- Add to tcore_param:
  - mem_res_t {valid, data[BLK_SIZE-1:0]}.
  - arb_state_e {IDLE, REQ, WAIT, RESP}.
  - arb_gnt_e {GNT_INSTR, GNT_DATA}.
- Sub-module: tcore_wmask_gen (combinational: addr[3:0], rw, rw_size, uncached → 16-bit mask), reusable by the dcache uncached path.

Test Plan:
- Instruction read: iX valid, addr 0x8000_0014, cached, memory ready, response data 0x…CAFE next cycle → mem_req_o.addr=0x8000_0010, rw=0; iX_res_o.valid with blk=0x…CAFE 3 cycles after request; dX_res_o.valid=0.
- Simultaneous requests after reset: both valid → instruction granted first, data second, instruction again on a third back-to-back pair; iX_res_o.ready/dX_res_o.ready pulse once each.
- Uncached writes at addr 0x1003: BYTE → rw=16'h0008; HALF_WORD at 0x1006 → 16'h00C0; WORD at 0x100C → 16'hF000; cached write → 16'hFFFF; addr unchanged when uncached.
- Backpressure: mem_ready_i low 5 cycles then high, and requester ready low 4 cycles in RESP → mem_req_o fields stable throughout; res.valid held with the same blk until ready.
- Timeout with TIMEOUT_CYC=8 and no memory response → err_o pulses exactly once, 8 cycles after REQ→WAIT; response data=0; arbiter returns to IDLE and serves the next request normally.
- rst_ni low during WAIT → all outputs 0 asynchronously; a mem_res_i.valid arriving after release is ignored; rr_last resets so instruction wins the next tie.

Source files
------------

// File: rtl/tcore_mem_arbiter_pkg.sv
// Shared types for the lowX-to-memory arbiter: requester/response bundles,
// the external memory port and the arbiter FSM/grant encodings.
package tcore_mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BLK_SIZE = 128;
  localparam int unsigned MASK_W   = BLK_SIZE / 8;

  typedef enum logic [1:0] {
    NO_SIZE   = 2'b00,
    BYTE      = 2'b01,
    HALF_WORD = 2'b10,
    WORD      = 2'b11
  } rw_size_e;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } ilowX_res_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [ADDR_W-1:0]   addr;
    logic [BLK_SIZE-1:0] data;
    logic                rw;
    rw_size_e            rw_size;
    logic                uncached;
  } dlowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [BLK_SIZE-1:0] data;
    logic [MASK_W-1:0]   rw;
  } mem_req_t;

  typedef struct packed {
    logic                valid;
    logic [BLK_SIZE-1:0] data;
  } mem_res_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } arb_state_e;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/tcore_wmask_gen.sv
// Byte-write mask for a 16-byte block: full block for cached stores, only the
// lanes covered by the access size for uncached stores, none for reads.
module tcore_wmask_gen
  import tcore_mem_arbiter_pkg::*;
(
  input  logic        [3:0]  addr,
  input  logic               rw,
  input  rw_size_e           rw_size,
  input  logic               uncached,
  output logic        [15:0] mask
);

  // uncached lanes are aligned down to the access size
  always_comb begin
    mask = 16'h0000;
    if (!rw) begin
      mask = 16'h0000;
    end else if (!uncached) begin
      mask = 16'hFFFF;
    end else begin
      case (rw_size)
        BYTE:      mask = 16'h0001 << addr;
        HALF_WORD: mask = 16'h0003 << {addr[3:1], 1'b0};
        WORD:      mask = 16'h000F << {addr[3:2], 2'b00};
        NO_SIZE:   mask = 16'h0000;
        default:   mask = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/tcore_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction and data
// lowX paths, one transaction outstanding, with a bounded response timeout.
module tcore_mem_arbiter
  import tcore_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  ilowX_req_t iX_req_i,
  output ilowX_res_t iX_res_o,
  input  dlowX_req_t dX_req_i,
  output dlowX_res_t dX_res_o,
  output mem_req_t   mem_req_o,
  input  logic       mem_ready_i,
  input  mem_res_t   mem_res_i,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  arb_state_e       state_r, state_s;
  arb_gnt_e         gnt_r, gnt_s;
  arb_gnt_e         rr_last_r, rr_last_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  mem_req_t         mem_req_r, mem_req_s;
  ilowX_res_t       i_res_r, i_res_s;
  dlowX_res_t       d_res_r, d_res_s;
  logic             err_r, err_s;
  logic [15:0]      d_mask_s;
  logic             pick_data_s;
  logic             timeout_s;
  logic             gnt_ready_s;

  tcore_wmask_gen u_wmask_gen (
    .addr     (dX_req_i.addr[3:0]),
    .rw       (dX_req_i.rw),
    .rw_size  (dX_req_i.rw_size),
    .uncached (dX_req_i.uncached),
    .mask     (d_mask_s)
  );

  assign timeout_s   = (TIMEOUT_CYC != 0) && (cnt_r == TO_LAST);
  assign gnt_ready_s = (gnt_r == GNT_DATA) ? dX_req_i.ready : iX_req_i.ready;

  // next-state and next-output logic; accept pulses last exactly one cycle
  always_comb begin
    state_s       = state_r;
    gnt_s         = gnt_r;
    rr_last_s     = rr_last_r;
    cnt_s         = cnt_r;
    mem_req_s     = mem_req_r;
    i_res_s       = i_res_r;
    d_res_s       = d_res_r;
    err_s         = 1'b0;
    pick_data_s   = 1'b0;
    i_res_s.ready = 1'b0;
    d_res_s.ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (iX_req_i.valid && dX_req_i.valid) begin
          pick_data_s = (rr_last_r == GNT_INSTR);
        end else begin
          pick_data_s = dX_req_i.valid;
        end
        if (iX_req_i.valid || dX_req_i.valid) begin
          state_s         = REQ;
          mem_req_s.valid = 1'b1;
          if (pick_data_s) begin
            gnt_s          = GNT_DATA;
            d_res_s.ready  = 1'b1;
            mem_req_s.addr = dX_req_i.uncached ? dX_req_i.addr
                                               : {dX_req_i.addr[31:4], 4'b0000};
            mem_req_s.data = dX_req_i.data;
            mem_req_s.rw   = d_mask_s;
          end else begin
            gnt_s          = GNT_INSTR;
            i_res_s.ready  = 1'b1;
            mem_req_s.addr = iX_req_i.uncached ? iX_req_i.addr
                                               : {iX_req_i.addr[31:4], 4'b0000};
            mem_req_s.data = {BLK_SIZE{1'b0}};
            mem_req_s.rw   = 16'h0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          state_s         = WAIT;
          mem_req_s.valid = 1'b0;
          cnt_s           = {CNT_W{1'b0}};
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        cnt_s = cnt_r + CNT_W'(1);
        // a real response in the timeout cycle wins over the error
        if (mem_res_i.valid || timeout_s) begin
          state_s = RESP;
          err_s   = !mem_res_i.valid;
          if (gnt_r == GNT_DATA) begin
            d_res_s.valid = 1'b1;
            d_res_s.data  = mem_res_i.valid ? mem_res_i.data : {BLK_SIZE{1'b0}};
          end else begin
            i_res_s.valid = 1'b1;
            i_res_s.blk   = mem_res_i.valid ? mem_res_i.data : {BLK_SIZE{1'b0}};
          end
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (gnt_ready_s) begin
          state_s       = IDLE;
          rr_last_s     = gnt_r;
          i_res_s.valid = 1'b0;
          d_res_s.valid = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, round-robin history, timeout counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      gnt_r     <= GNT_INSTR;
      rr_last_r <= GNT_DATA;
      cnt_r     <= {CNT_W{1'b0}};
      mem_req_r <= '0;
      i_res_r   <= '0;
      d_res_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      rr_last_r <= rr_last_s;
      cnt_r     <= cnt_s;
      mem_req_r <= mem_req_s;
      i_res_r   <= i_res_s;
      d_res_r   <= d_res_s;
      err_r     <= err_s;
    end
  end

  assign iX_res_o  = i_res_r;
  assign dX_res_o  = d_res_r;
  assign mem_req_o = mem_req_r;
  assign err_o     = err_r;

endmodule

// File: tb/tb_tcore_mem_arbiter.sv
// Scoreboard bench for tcore_mem_arbiter: stimulus pushes expected memory
// requests and responses; memory model and response monitor pop and compare.
module tb_tcore_mem_arbiter;
  import tcore_mem_arbiter_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  ilowX_req_t iX_req_i = '0;
  ilowX_res_t iX_res_o;
  dlowX_req_t dX_req_i = '0;
  dlowX_res_t dX_res_o;
  mem_req_t   mem_req_o;
  logic       mem_ready_i;
  mem_res_t   mem_res_i;
  logic       err_o;

  int chk_cnt = 0, pass_cnt = 0, cyc = 0;
  mem_req_t      exp_mem_q[$];
  logic [127:0]  i_exp_q[$];
  logic [127:0]  d_exp_q[$];
  arb_gnt_e rr_last_m = GNT_DATA;
  bit  mem_silent = 1'b0, mem_fast = 1'b0;
  int  spur_req = 0, bp_req = 0, mem_accepts = 0, accept_cyc = 0;
  int  exp_i_rdy = 0, exp_d_rdy = 0, exp_err = 0;
  int  i_rdy_cnt = 0, d_rdy_cnt = 0, err_cnt = 0;

  tcore_mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .iX_req_i(iX_req_i), .iX_res_o(iX_res_o),
    .dX_req_i(dX_req_i), .dX_res_o(dX_res_o), .mem_req_o(mem_req_o),
    .mem_ready_i(mem_ready_i), .mem_res_i(mem_res_i), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory contents as a fixed function of the block address.
  function automatic logic [127:0] mem_fn(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h0000_1234, 32'h0000_CAFE};
  endfunction

  // Lane enables from byte ranges: [aligned start, start+size).
  function automatic logic [15:0] ref_mask(input logic [31:0] a, input logic rw,
                                           input rw_size_e sz, input logic unc);
    int n, start;
    logic [15:0] m;
    m = 16'h0000;
    if (!rw) return 16'h0000;
    if (!unc) return 16'hFFFF;
    case (sz)
      BYTE:      n = 1;
      HALF_WORD: n = 2;
      WORD:      n = 4;
      default:   n = 0;
    endcase
    if (n == 0) return 16'h0000;
    start = (int'(a[3:0]) / n) * n;
    for (int b = 0; b < 16; b++) if (b >= start && b < start + n) m[b] = 1'b1;
    return m;
  endfunction

  // Memory model: accepts requests, checks them, answers after a random delay.
  initial begin : mem_model
    int resp_cnt, stall_left, spur_done, bp_done;
    logic resp_pending;
    logic [127:0] resp_data;
    resp_cnt = 0; stall_left = 0; spur_done = 0; bp_done = 0;
    resp_pending = 1'b0; resp_data = '0;
    mem_ready_i = 1'b0; mem_res_i = '0;
    forever begin
      @(negedge clk);
      mem_res_i = '0;
      if (!rst_ni) begin
        resp_pending = 1'b0;
        mem_ready_i  = 1'b0;
      end else begin
        if (bp_req != bp_done) begin stall_left = 5; bp_done = bp_req; end
        if (resp_pending) begin
          if (resp_cnt == 0) begin
            mem_res_i.valid = 1'b1; mem_res_i.data = resp_data; resp_pending = 1'b0;
          end else resp_cnt--;
        end else if (spur_req != spur_done ||
                     (!mem_silent && $urandom_range(0, 7) == 0)) begin
          spur_done = spur_req;
          mem_res_i.valid = 1'b1;
          mem_res_i.data  = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_ready_i = mem_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (mem_req_o.valid) begin
          if (stall_left > 0) begin mem_ready_i = 1'b0; stall_left--; end
          if (exp_mem_q.size() == 0) fail_now("mem_unexpected_req");
          else begin
            chk("mem_req", {mem_req_o.addr, mem_req_o.data, mem_req_o.rw},
                {exp_mem_q[0].addr, exp_mem_q[0].data, exp_mem_q[0].rw});
            if (mem_ready_i) begin
              void'(exp_mem_q.pop_front());
              accept_cyc = cyc + 1;
              mem_accepts++;
              if (!mem_silent) begin
                resp_pending = 1'b1;
                resp_cnt  = mem_fast ? 0 : $urandom_range(0, 3);
                resp_data = mem_fn(mem_req_o.addr);
              end
            end
          end
        end
      end
    end
  end

  // Response monitor: compares presented responses and counts pulses.
  initial begin : resp_mon
    logic i_prev, d_prev;
    i_prev = 1'b0; d_prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst_ni) begin
        i_prev = 1'b0; d_prev = 1'b0;
      end else begin
        if (iX_res_o.valid) begin
          chk("one_side_valid", 192'(dX_res_o.valid), 192'(0));
          if (i_exp_q.size() == 0) fail_now("i_unexpected_resp");
          else begin
            chk("i_blk", 192'(iX_res_o.blk), 192'(i_exp_q[0]));
            if (iX_req_i.ready) void'(i_exp_q.pop_front());
          end
        end
        if (dX_res_o.valid) begin
          if (d_exp_q.size() == 0) fail_now("d_unexpected_resp");
          else begin
            chk("d_data", 192'(dX_res_o.data), 192'(d_exp_q[0]));
            if (dX_req_i.ready) void'(d_exp_q.pop_front());
          end
        end
        if (iX_res_o.ready) begin i_rdy_cnt++; chk("i_ready_pulse", 192'(i_prev), 192'(0)); end
        if (dX_res_o.ready) begin d_rdy_cnt++; chk("d_ready_pulse", 192'(d_prev), 192'(0)); end
        i_prev = iX_res_o.ready; d_prev = dX_res_o.ready;
        if (err_o) begin
          err_cnt++;
          chk("err_delay", 192'(cyc - accept_cyc), 192'(TO));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic i_xact(input logic [31:0] a, input logic u, input int rdly, input bit lat);
    int n, t0;
    iX_req_i.addr = a; iX_req_i.uncached = u; iX_req_i.ready = 1'b0; iX_req_i.valid = 1'b1;
    t0 = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!iX_res_o.valid && n < 300);
    if (!iX_res_o.valid) begin fail_now("i_resp_wait"); iX_req_i = '0; return; end
    if (lat) chk("i_latency", 192'(cyc - t0), 192'(3));
    repeat (rdly) @(negedge clk);
    iX_req_i.ready = 1'b1;
    @(negedge clk);
    iX_req_i = '0;
  endtask

  task automatic d_xact(input logic [31:0] a, input logic [127:0] d, input logic rw,
                        input rw_size_e sz, input logic u, input int rdly);
    int n;
    dX_req_i.addr = a; dX_req_i.data = d; dX_req_i.rw = rw; dX_req_i.rw_size = sz;
    dX_req_i.uncached = u; dX_req_i.ready = 1'b0; dX_req_i.valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dX_res_o.valid && n < 300);
    if (!dX_res_o.valid) begin fail_now("d_resp_wait"); dX_req_i = '0; return; end
    repeat (rdly) @(negedge clk);
    dX_req_i.ready = 1'b1;
    @(negedge clk);
    dX_req_i = '0;
  endtask

  // kind: 0 instruction only, 1 data only, 2 both in the same cycle
  task automatic run_round(input int kind, input logic [31:0] ia, input logic iu,
                           input logic [31:0] da, input logic [127:0] dd, input logic drw,
                           input rw_size_e dsz, input logic du, input int ri, input int rd,
                           input bit lat);
    mem_req_t ie, de;
    bit data_first;
    ie = '0; de = '0;
    ie.addr = iu ? ia : {ia[31:4], 4'h0};
    de.addr = du ? da : {da[31:4], 4'h0};
    de.data = dd;
    de.rw   = ref_mask(da, drw, dsz, du);
    data_first = (kind == 1) || (kind == 2 && rr_last_m == GNT_INSTR);
    if (kind != 1 && !data_first) exp_mem_q.push_back(ie);
    if (kind != 0) exp_mem_q.push_back(de);
    if (kind != 1 && data_first) exp_mem_q.push_back(ie);
    if (kind != 1) begin
      i_exp_q.push_back(mem_silent ? 128'h0 : mem_fn(ie.addr)); exp_i_rdy++;
    end
    if (kind != 0) begin
      d_exp_q.push_back(mem_silent ? 128'h0 : mem_fn(de.addr)); exp_d_rdy++;
    end
    if (mem_silent) exp_err += (kind == 2) ? 2 : 1;
    if (kind == 0) rr_last_m = GNT_INSTR;
    else if (kind == 1) rr_last_m = GNT_DATA;
    else rr_last_m = data_first ? GNT_INSTR : GNT_DATA;
    fork
      if (kind != 1) i_xact(ia, iu, ri, lat);
      if (kind != 0) d_xact(da, dd, drw, dsz, du, rd);
    join
  endtask

  task automatic rand_round(input int kind);
    run_round(kind, $urandom, 1'($urandom_range(0, 1)), $urandom,
              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
              rw_size_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
  endtask

  initial begin : stim
    int n, acc0;
    logic [127:0] wd;
    wd = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    #12;
    chk("reset_i_res", 192'(iX_res_o), 192'(0));
    chk("reset_d_res", 192'(dX_res_o), 192'(0));
    chk("reset_mem_req", 192'(mem_req_o), 192'(0));
    chk("reset_err", 192'(err_o), 192'(0));
    @(negedge clk); rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // cached fetch with an always-ready memory
    mem_fast = 1'b1;
    run_round(0, 32'h8000_0014, 1'b0, 32'h0, 128'h0, 1'b0, NO_SIZE, 1'b0, 0, 0, 1'b1);
    mem_fast = 1'b0;
    repeat (3) rand_round(2);

    // uncached and cached write masks
    run_round(1, 0, 0, 32'h0000_1003, wd, 1'b1, BYTE,      1'b1, 0, 1, 1'b0);
    run_round(1, 0, 0, 32'h0000_1006, wd, 1'b1, HALF_WORD, 1'b1, 0, 0, 1'b0);
    run_round(1, 0, 0, 32'h0000_100C, wd, 1'b1, WORD,      1'b1, 0, 2, 1'b0);
    run_round(1, 0, 0, 32'h0000_2005, wd, 1'b1, WORD,      1'b0, 0, 0, 1'b0);
    run_round(1, 0, 0, 32'h0000_3007, wd, 1'b1, NO_SIZE,   1'b1, 0, 0, 1'b0);

    // memory and requester backpressure
    bp_req++;
    run_round(0, 32'h4000_0104, 1'b1, 0, 0, 1'b0, NO_SIZE, 1'b0, 4, 0, 1'b0);
    bp_req++;
    run_round(1, 0, 0, 32'h4000_0202, wd, 1'b1, HALF_WORD, 1'b1, 0, 4, 1'b0);

    // timeout, then normal service
    mem_silent = 1'b1;
    run_round(0, 32'h9000_0040, 1'b0, 0, 0, 1'b0, NO_SIZE, 1'b0, 1, 0, 1'b0);
    run_round(1, 0, 0, 32'h9000_0080, wd, 1'b0, NO_SIZE, 1'b0, 0, 0, 1'b0);
    mem_silent = 1'b0;
    rand_round(2);

    for (int r = 0; r < 40; r++) rand_round($urandom_range(0, 2));

    // asynchronous reset while waiting for memory
    mem_silent = 1'b1;
    begin
      mem_req_t ie;
      ie = '0; ie.addr = 32'h7000_0010;
      exp_mem_q.push_back(ie); exp_i_rdy++;
    end
    acc0 = mem_accepts;
    iX_req_i.addr = 32'h7000_0018; iX_req_i.uncached = 1'b0; iX_req_i.valid = 1'b1;
    n = 0;
    while (mem_accepts == acc0 && n < 100) begin @(negedge clk); n++; end
    if (mem_accepts == acc0) fail_now("rst_test_accept_wait");
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_i_res", 192'(iX_res_o), 192'(0));
    chk("async_rst_d_res", 192'(dX_res_o), 192'(0));
    chk("async_rst_mem_req", 192'(mem_req_o), 192'(0));
    chk("async_rst_err", 192'(err_o), 192'(0));
    iX_req_i = '0;
    i_exp_q.delete(); d_exp_q.delete(); exp_mem_q.delete();
    rr_last_m = GNT_DATA;
    @(negedge clk); rst_ni = 1'b1; mem_silent = 1'b0; spur_req++;
    repeat (4) @(negedge clk);
    run_round(2, 32'h6000_0020, 1'b0, 32'h6000_0031, wd, 1'b1, BYTE, 1'b1, 0, 0, 1'b0);
    rand_round(2);
    repeat (5) @(negedge clk);

    chk("i_ready_pulses", 192'(i_rdy_cnt), 192'(exp_i_rdy));
    chk("d_ready_pulses", 192'(d_rdy_cnt), 192'(exp_d_rdy));
    chk("err_pulses", 192'(err_cnt), 192'(exp_err));
    chk("queues_drained", 192'(i_exp_q.size() + d_exp_q.size() + exp_mem_q.size()), 192'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
